// File: rtl/ahb_mem_slave_pkg.sv
// ---------------------------------------------------------------------------
// ahb_slave_pkg
//   Shared types and constants for the word-addressed AHB SRAM slave.
//   - state_t    : slave FSM states (IDLE / BUSY / DONE / ERR)
//   - RESP_OKAY  : HRESP encoding for a successful transfer
//   - RESP_ERROR : HRESP encoding for a refused transfer
//   - WAIT_CNT_W : width of the wait-state counter (WAIT_STATES <= 15)
// ---------------------------------------------------------------------------
package ahb_slave_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;

    localparam int WAIT_CNT_W = 4;

endpackage : ahb_slave_pkg

// File: rtl/ahb_mem_slave_if.sv
// ---------------------------------------------------------------------------
// ahb_mem_slave_if
//   Request/response bundle between the AHB slave wrapper and the SRAM slave.
//   Request  (master -> slave): addr, write_data, write_en, read_en
//   Response (slave -> master): read_data, ready, resp
//   write_en / read_en are one-cycle pulses; addr and write_data are valid
//   alongside them.
// ---------------------------------------------------------------------------
interface ahb_mem_slave_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) ();

    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  write_en;
    logic                  read_en;
    logic [DATA_WIDTH-1:0] read_data;
    logic                  ready;
    logic [1:0]            resp;

    modport master (
        output addr,
        output write_data,
        output write_en,
        output read_en,
        input  read_data,
        input  ready,
        input  resp
    );

    modport slave (
        input  addr,
        input  write_data,
        input  write_en,
        input  read_en,
        output read_data,
        output ready,
        output resp
    );

endinterface : ahb_mem_slave_if

// File: rtl/ahb_mem_slave_array.sv
// ---------------------------------------------------------------------------
// ahb_mem_array
//   MEM_DEPTH x DATA_WIDTH storage for the SRAM slave.
//   Ports:
//     Hclk, Hresetn : clock, asynchronous active-low reset (read register only)
//     we            : write strobe, stores wdata at idx on the clock edge
//     re            : read-commit strobe, loads mem[idx] into rdata
//     idx           : word index
//     wdata         : write data
//     rdata         : registered read data, holds its value until next re
//   The array itself has no reset; only the read register is cleared.
// ---------------------------------------------------------------------------
module ahb_mem_array #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024,
    localparam int IDX_W     = $clog2(MEM_DEPTH)
) (
    input  logic                  Hclk,
    input  logic                  Hresetn,
    input  logic                  we,
    input  logic                  re,
    input  logic [IDX_W-1:0]      idx,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    always_ff @(posedge Hclk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[idx];
        end
    end

endmodule : ahb_mem_array

// File: rtl/ahb_mem_slave.sv
// ---------------------------------------------------------------------------
// ahb_mem_slave
//   Word-addressed SRAM slave sitting behind the AHB slave wrapper. Accepts
//   one-cycle read/write pulses, inserts WAIT_STATES ready-low cycles for a
//   good access and answers bad accesses with the two-cycle AHB ERROR.
//
//   Ports:
//     Hclk    : clock
//     Hresetn : asynchronous active-low reset
//     wp      : write protect (only with MEM_WRITE_PROTECT_EN defined)
//     bus     : ahb_mem_slave_if.slave (addr, write_data, write_en, read_en
//               in; read_data, ready, resp out)
//
//   Optional feature macro: MEM_WRITE_PROTECT_EN
//     Adds the wp input; a write to a valid address while wp=1 is refused
//     with ERROR and leaves memory untouched. Without the macro, writes are
//     never refused.
// ---------------------------------------------------------------------------
module ahb_mem_slave
    import ahb_slave_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    MEM_DEPTH   = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_STATES = 1
) (
    input  logic Hclk,
    input  logic Hresetn,
`ifdef MEM_WRITE_PROTECT_EN
    input  logic wp,
`endif
    ahb_mem_slave_if.slave bus
);

    localparam int BYTES    = DATA_WIDTH / 8;
    localparam int IDX_W    = $clog2(MEM_DEPTH);
    localparam int BYTE_LSB = $clog2(BYTES);

    localparam logic [ADDR_WIDTH-1:0] MEM_BYTES  = ADDR_WIDTH'(MEM_DEPTH * BYTES);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(BYTES - 1);
    localparam logic [WAIT_CNT_W-1:0] LAST_CNT   = WAIT_CNT_W'(WAIT_STATES - 1);
    localparam bit                    SINGLE_WAIT = (WAIT_STATES == 1);

    state_t                  state_p1;
    state_t                  state_nxt;
    logic [WAIT_CNT_W-1:0]   cnt_p1;

    logic [IDX_W-1:0]        idx_p1;
    logic [DATA_WIDTH-1:0]   wdata_p1;
    logic                    wr_p1;

    logic                    pulse_p0;
    logic [ADDR_WIDTH-1:0]   offset_p0;
    logic                    in_range_p0;
    logic                    misaligned_p0;
    logic                    wp_err_p0;
    logic                    dec_err_p0;
    logic                    ok_pulse_p0;
    logic                    err_pulse_p0;
    logic [IDX_W-1:0]        live_idx_p0;

    logic                    commit_p0;
    logic                    commit_wr_p0;
    logic                    mem_we_p0;
    logic                    mem_re_p0;
    logic [IDX_W-1:0]        mem_idx_p0;
    logic [DATA_WIDTH-1:0]   mem_wdata_p0;
    logic [DATA_WIDTH-1:0]   rd_data_p2;

    // ---- p0: request decode (same cycle as the pulse) ----
    // Pulses arriving outside IDLE are dropped here.
    assign pulse_p0  = (state_p1 == ST_IDLE) && (bus.write_en || bus.read_en);

    // Offset compare avoids overflow of BASE_ADDR + span near the top of
    // the address map.
    assign offset_p0     = bus.addr - BASE_ADDR;
    assign in_range_p0   = (bus.addr >= BASE_ADDR) && (offset_p0 < MEM_BYTES);
    assign misaligned_p0 = |(bus.addr & ALIGN_MASK);

`ifdef MEM_WRITE_PROTECT_EN
    assign wp_err_p0 = bus.write_en && wp;
`else
    assign wp_err_p0 = 1'b0;
`endif

    assign dec_err_p0   = !in_range_p0 || misaligned_p0 || wp_err_p0;
    assign ok_pulse_p0  = pulse_p0 && !dec_err_p0;
    assign err_pulse_p0 = pulse_p0 && dec_err_p0;
    assign live_idx_p0  = offset_p0[BYTE_LSB +: IDX_W];

    // The counter holds the number of ready-low cycles already completed, so
    // the commit edge is the one that ends low cycle number WAIT_STATES.
    // With a single wait state the commit happens at the end of the pulse
    // cycle itself, using the live request rather than the latched copy.
    assign commit_p0 = (ok_pulse_p0 && SINGLE_WAIT) ||
                       ((state_p1 == ST_BUSY) && (cnt_p1 == LAST_CNT));

    // write_en wins when both enables are raised together.
    assign commit_wr_p0 = (state_p1 == ST_IDLE) ? bus.write_en : wr_p1;
    assign mem_we_p0    = commit_p0 && commit_wr_p0;
    assign mem_re_p0    = commit_p0 && !commit_wr_p0;
    assign mem_idx_p0   = (state_p1 == ST_IDLE) ? live_idx_p0 : idx_p1;
    assign mem_wdata_p0 = (state_p1 == ST_IDLE) ? bus.write_data : wdata_p1;

    always_comb begin
        state_nxt = state_p1;
        case (state_p1)
            ST_IDLE: begin
                if (err_pulse_p0) begin
                    state_nxt = ST_ERR;
                end else if (ok_pulse_p0) begin
                    state_nxt = SINGLE_WAIT ? ST_DONE : ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (commit_p0) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            ST_ERR:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // ---- p1: control state and latched request ----
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state_p1 <= ST_IDLE;
            cnt_p1   <= '0;
        end else begin
            state_p1 <= state_nxt;
            // Reloaded on every accepted pulse, so it never wraps.
            if (ok_pulse_p0) begin
                cnt_p1 <= WAIT_CNT_W'(1);
            end else if (state_p1 == ST_BUSY) begin
                cnt_p1 <= cnt_p1 + WAIT_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge Hclk) begin
        if (ok_pulse_p0) begin
            idx_p1   <= live_idx_p0;
            wdata_p1 <= bus.write_data;
            wr_p1    <= bus.write_en;
        end
    end

    // ---- p2: storage and read register ----
    ahb_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_array (
        .Hclk    (Hclk),
        .Hresetn (Hresetn),
        .we      (mem_we_p0),
        .re      (mem_re_p0),
        .idx     (mem_idx_p0),
        .wdata   (mem_wdata_p0),
        .rdata   (rd_data_p2)
    );

    // ---- response outputs ----
    // ready drops combinationally in the pulse cycle for both the OKAY and
    // the ERROR path; ERR is the second (ready-high) half of the ERROR.
    assign bus.read_data = rd_data_p2;
    assign bus.ready     = !(pulse_p0 || (state_p1 == ST_BUSY));
    assign bus.resp      = (err_pulse_p0 || (state_p1 == ST_ERR)) ? RESP_ERROR : RESP_OKAY;

    // The wrapper gates requests on ready, so these indicate a wrapper fault.
    a_no_pulse_when_busy: assert property (
        @(posedge Hclk) disable iff (!Hresetn)
        (state_p1 != ST_IDLE) |-> !(bus.write_en || bus.read_en)
    );

    a_no_dual_enable: assert property (
        @(posedge Hclk) disable iff (!Hresetn)
        !(bus.write_en && bus.read_en)
    );

endmodule : ahb_mem_slave

// File: tb/tb_ahb_mem_slave.sv
// ---------------------------------------------------------------------------
// tb_ahb_mem_slave
//   Two slaves (WAIT_STATES=1 and 3) receive the same request stream; a
//   sparse memory model plus a read-data model gives the expected response
//   for every cycle of every access.
// ---------------------------------------------------------------------------
module tb_ahb_mem_slave;
    import ahb_slave_pkg::*;

    localparam logic [31:0] BASE = 32'h0001_0000;
    localparam logic [31:0] SPAN = 32'h0000_1000;

    logic Hclk    = 1'b0;
    logic Hresetn = 1'b0;
`ifdef MEM_WRITE_PROTECT_EN
    logic wp = 1'b0;
`endif

    ahb_mem_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if1 ();
    ahb_mem_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if3 ();

    ahb_mem_slave #(.MEM_DEPTH(1024), .BASE_ADDR(BASE), .WAIT_STATES(1)) dut1 (
        .Hclk    (Hclk),
        .Hresetn (Hresetn),
`ifdef MEM_WRITE_PROTECT_EN
        .wp      (wp),
`endif
        .bus     (if1)
    );

    ahb_mem_slave #(.MEM_DEPTH(1024), .BASE_ADDR(BASE), .WAIT_STATES(3)) dut3 (
        .Hclk    (Hclk),
        .Hresetn (Hresetn),
`ifdef MEM_WRITE_PROTECT_EN
        .wp      (wp),
`endif
        .bus     (if3)
    );

    always #5 Hclk = ~Hclk;

    int checks   = 0;
    int failures = 0;
    int ws_of [2] = '{1, 3};

    logic        smp_rdy [2][4];
    logic [1:0]  smp_rsp [2][4];
    logic [31:0] smp_rd  [2][4];

    logic [31:0] mem_m [logic [31:0]];
    logic [31:0] rd_m = 32'h0;

    function automatic logic get_rdy(input int k);
        return (k == 0) ? if1.ready : if3.ready;
    endfunction

    function automatic logic [1:0] get_rsp(input int k);
        return (k == 0) ? if1.resp : if3.resp;
    endfunction

    function automatic logic [31:0] get_rd(input int k);
        return (k == 0) ? if1.read_data : if3.read_data;
    endfunction

    // Reference decode: out of window, misaligned, or protected write.
    function automatic bit model_err(input bit wr, input logic [31:0] a, input bit wpv);
        logic [1:0] lo;
        lo = a[1:0];
        return (a < BASE) || (a >= BASE + SPAN) || (lo != 2'b00) || (wr && wpv);
    endfunction

    task automatic drive(input bit en, input bit wr, input logic [31:0] a, input logic [31:0] d);
        if1.addr = a;  if1.write_data = d;  if1.write_en = en && wr;  if1.read_en = en && !wr;
        if3.addr = a;  if3.write_data = d;  if3.write_en = en && wr;  if3.read_en = en && !wr;
    endtask

    // One request pulse, then four sampled cycles (pulse cycle = index 0).
    task automatic run_access(input bit wr, input logic [31:0] a, input logic [31:0] d, input bit wpv);
        @(posedge Hclk);
        #1;
        drive(1'b1, wr, a, d);
`ifdef MEM_WRITE_PROTECT_EN
        wp = wpv;
`endif
        for (int c = 0; c < 4; c++) begin
            @(negedge Hclk);
            for (int k = 0; k < 2; k++) begin
                smp_rdy[k][c] = get_rdy(k);
                smp_rsp[k][c] = get_rsp(k);
                smp_rd[k][c]  = get_rd(k);
            end
            if (c == 0) begin
                @(posedge Hclk);
                #1;
                drive(1'b0, 1'b0, 32'h0, 32'h0);
`ifdef MEM_WRITE_PROTECT_EN
                wp = 1'b0;
`endif
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge Hclk);
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (get_rdy(k) !== 1'b1 || get_rsp(k) !== RESP_OKAY || get_rd(k) !== 32'h0) begin
                failures++;
                $display("FAIL reset dut%0d ready=%b resp=%b rd=%h want ready=1 resp=00 rd=0",
                         k, get_rdy(k), get_rsp(k), get_rd(k));
            end
        end
        @(negedge Hclk);
        Hresetn = 1'b1;
    endtask

    task automatic test_ws1_write_read();
        logic [31:0] a;
        int low;
        a = BASE + 32'h10;
        run_access(1'b1, a, 32'hDEAD_BEEF, 1'b0);
        mem_m[a] = 32'hDEAD_BEEF;
        for (int k = 0; k < 2; k++) begin
            low = 0;
            for (int c = 0; c < 4; c++) if (!smp_rdy[k][c]) low++;
            checks++;
            if (low != ws_of[k] || smp_rdy[k][ws_of[k]] !== 1'b1 || smp_rsp[k][ws_of[k]] !== RESP_OKAY) begin
                failures++;
                $display("FAIL write_lat dut%0d low=%0d ready=%b resp=%b want low=%0d ready=1 resp=00",
                         k, low, smp_rdy[k][ws_of[k]], smp_rsp[k][ws_of[k]], ws_of[k]);
            end
        end
        run_access(1'b0, a, 32'h0, 1'b0);
        rd_m = 32'hDEAD_BEEF;
        for (int k = 0; k < 2; k++) begin
            low = 0;
            for (int c = 0; c < 4; c++) if (!smp_rdy[k][c]) low++;
            checks++;
            if (low != ws_of[k] || smp_rd[k][ws_of[k]] !== 32'hDEAD_BEEF || smp_rsp[k][ws_of[k]] !== RESP_OKAY) begin
                failures++;
                $display("FAIL read_back dut%0d low=%0d rd=%h resp=%b want low=%0d rd=deadbeef resp=00",
                         k, low, smp_rd[k][ws_of[k]], smp_rsp[k][ws_of[k]], ws_of[k]);
            end
        end
    endtask

    task automatic test_ws3_read();
        logic [31:0] d;
        d = $urandom;
        run_access(1'b1, BASE, d, 1'b0);
        mem_m[BASE] = d;
        run_access(1'b0, BASE, 32'h0, 1'b0);
        rd_m = d;
        checks++;
        if ({smp_rdy[1][0], smp_rdy[1][1], smp_rdy[1][2], smp_rdy[1][3]} !== 4'b0001 || smp_rd[1][3] !== d) begin
            failures++;
            $display("FAIL ws3_read ready=%b%b%b%b rd=%h want ready=0001 rd=%h",
                     smp_rdy[1][0], smp_rdy[1][1], smp_rdy[1][2], smp_rdy[1][3], smp_rd[1][3], d);
        end
        checks++;
        if (smp_rd[1][2] === d && d !== smp_rd[1][0]) begin
            failures++;
            $display("FAIL ws3_early rd=%h before ready, want %h held", smp_rd[1][2], smp_rd[1][0]);
        end
    endtask

    task automatic test_error_addr(input string nm, input bit wr, input logic [31:0] a);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (smp_rdy[k][0] !== 1'b0 || smp_rsp[k][0] !== RESP_ERROR ||
                smp_rdy[k][1] !== 1'b1 || smp_rsp[k][1] !== RESP_ERROR ||
                smp_rdy[k][2] !== 1'b1 || smp_rsp[k][2] !== RESP_OKAY ||
                smp_rd[k][3] !== rd_m) begin
                failures++;
                $display("FAIL %s dut%0d wr=%0d a=%h c0=%b/%b c1=%b/%b c2=%b/%b rd=%h want 0/01 1/01 1/00 rd=%h",
                         nm, k, wr, a, smp_rdy[k][0], smp_rsp[k][0], smp_rdy[k][1], smp_rsp[k][1],
                         smp_rdy[k][2], smp_rsp[k][2], smp_rd[k][3], rd_m);
            end
        end
    endtask

    task automatic test_out_of_range();
        run_access(1'b0, BASE + SPAN, 32'h0, 1'b0);
        test_error_addr("oor_high", 1'b0, BASE + SPAN);
        run_access(1'b0, BASE - 32'h4, 32'h0, 1'b0);
        test_error_addr("oor_low", 1'b0, BASE - 32'h4);
    endtask

    task automatic test_misaligned();
        run_access(1'b1, BASE + 32'h4, 32'hA5A5_0F0F, 1'b0);
        mem_m[BASE + 32'h4] = 32'hA5A5_0F0F;
        run_access(1'b1, BASE + 32'h6, 32'h1111_2222, 1'b0);
        test_error_addr("misaligned", 1'b1, BASE + 32'h6);
        run_access(1'b0, BASE + 32'h4, 32'h0, 1'b0);
        rd_m = 32'hA5A5_0F0F;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (smp_rd[k][ws_of[k]] !== 32'hA5A5_0F0F) begin
                failures++;
                $display("FAIL misaligned_keep dut%0d rd=%h want a5a50f0f", k, smp_rd[k][ws_of[k]]);
            end
        end
    endtask

    task automatic test_last_word();
        logic [31:0] a;
        a = BASE + SPAN - 32'h4;
        run_access(1'b1, a, 32'h0BAD_F00D, 1'b0);
        mem_m[a] = 32'h0BAD_F00D;
        run_access(1'b0, a, 32'h0, 1'b0);
        rd_m = 32'h0BAD_F00D;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (smp_rd[k][ws_of[k]] !== 32'h0BAD_F00D || smp_rsp[k][0] !== RESP_OKAY) begin
                failures++;
                $display("FAIL last_word dut%0d rd=%h resp=%b want 0badf00d resp=00",
                         k, smp_rd[k][ws_of[k]], smp_rsp[k][0]);
            end
        end
    endtask

`ifdef MEM_WRITE_PROTECT_EN
    task automatic test_write_protect();
        logic [31:0] a;
        a = BASE + 32'h20;
        run_access(1'b1, a, 32'hCAFE_0001, 1'b0);
        mem_m[a] = 32'hCAFE_0001;
        run_access(1'b1, a, 32'h1234_5678, 1'b1);
        test_error_addr("wp_write", 1'b1, a);
        run_access(1'b0, a, 32'h0, 1'b1);
        rd_m = 32'hCAFE_0001;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (smp_rd[k][ws_of[k]] !== 32'hCAFE_0001 || smp_rsp[k][0] !== RESP_OKAY) begin
                failures++;
                $display("FAIL wp_read dut%0d rd=%h resp=%b want cafe0001 resp=00",
                         k, smp_rd[k][ws_of[k]], smp_rsp[k][0]);
            end
        end
    endtask
`endif

    task automatic test_random();
        logic [31:0] a, d, rd_before, exp_rd;
        bit wr, wpv, err;
        int kind;
        logic       exp_rdy;
        logic [1:0] exp_rsp;
        for (int n = 0; n < 80; n++) begin
            kind = $urandom_range(0, 9);
            wpv  = 1'b0;
`ifdef MEM_WRITE_PROTECT_EN
            wpv  = ($urandom_range(0, 3) == 0);
`endif
            wr = $urandom_range(0, 1);
            d  = $urandom;
            case (kind)
                0: a = BASE + SPAN + 32'($urandom_range(0, 255)) * 4;
                1: a = BASE - 32'($urandom_range(1, 64)) * 4;
                2: a = BASE + 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(1, 3));
                default: begin
                    a = BASE + 32'($urandom_range(0, 15)) * 4;
                    if (!mem_m.exists(a)) wr = 1'b1;
                end
            endcase
            err = model_err(wr, a, wpv);
            rd_before = rd_m;
            run_access(wr, a, d, wpv);
            if (!err) begin
                if (wr) mem_m[a] = d;
                else    rd_m = mem_m[a];
            end
            for (int k = 0; k < 2; k++) begin
                for (int c = 0; c < 4; c++) begin
                    if (err) begin
                        exp_rdy = (c != 0);
                        exp_rsp = (c <= 1) ? RESP_ERROR : RESP_OKAY;
                        exp_rd  = rd_before;
                    end else begin
                        exp_rdy = (c >= ws_of[k]);
                        exp_rsp = RESP_OKAY;
                        exp_rd  = (!wr && c >= ws_of[k]) ? rd_m : rd_before;
                    end
                    checks++;
                    if (smp_rdy[k][c] !== exp_rdy || smp_rsp[k][c] !== exp_rsp || smp_rd[k][c] !== exp_rd) begin
                        failures++;
                        $display("FAIL rand%0d dut%0d cyc%0d wr=%0d a=%h ready=%b/%b resp=%b/%b rd=%h/%h (got/want)",
                                 n, k, c, wr, a, smp_rdy[k][c], exp_rdy, smp_rsp[k][c], exp_rsp,
                                 smp_rd[k][c], exp_rd);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid_busy();
        logic [31:0] a;
        a = BASE + 32'h10;
        @(posedge Hclk);
        #1;
        drive(1'b1, 1'b0, a, 32'h0);
        @(posedge Hclk);
        #1;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        #2;
        checks++;
        if (if3.ready !== 1'b0) begin
            failures++;
            $display("FAIL busy_before_reset ready=%b want 0", if3.ready);
        end
        Hresetn = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (get_rdy(k) !== 1'b1 || get_rsp(k) !== RESP_OKAY || get_rd(k) !== 32'h0) begin
                failures++;
                $display("FAIL async_reset dut%0d ready=%b resp=%b rd=%h want ready=1 resp=00 rd=0",
                         k, get_rdy(k), get_rsp(k), get_rd(k));
            end
        end
        rd_m = 32'h0;
        @(negedge Hclk);
        @(negedge Hclk);
        Hresetn = 1'b1;
        run_access(1'b0, a, 32'h0, 1'b0);
        rd_m = mem_m[a];
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (smp_rdy[k][ws_of[k] - 1] !== 1'b0 || smp_rdy[k][ws_of[k]] !== 1'b1 ||
                smp_rd[k][ws_of[k]] !== rd_m) begin
                failures++;
                $display("FAIL after_reset dut%0d ready=%b%b rd=%h want ready=01 rd=%h",
                         k, smp_rdy[k][ws_of[k] - 1], smp_rdy[k][ws_of[k]], smp_rd[k][ws_of[k]], rd_m);
            end
        end
    endtask

    initial begin
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        test_reset();
        test_ws1_write_read();
        test_ws3_read();
        test_out_of_range();
        test_misaligned();
        test_last_word();
`ifdef MEM_WRITE_PROTECT_EN
        test_write_protect();
`endif
        test_random();
        test_reset_mid_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_ahb_mem_slave
